// File: rtl/dac_sweep_scheduler.sv
// Purpose: sequences the test chip's 8 on-die DACs over the chip serial pins from an 8-entry level table.
// Latency: first bit period begins the cycle after start is accepted; each bit lasts CLK_DIV cycles.
// Backpressure: none; start is ignored while busy, table writes are accepted every cycle.
module dac_sweep_scheduler #(
  parameter int CLK_DIV = 4000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] ch_mask,
  input  logic       start,
  input  logic       loop_en,
  output logic       busy,
  output logic       done,
  output logic       chip_rst,
  output logic       chip_clk,
  output logic       chip_data_in
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  // EMPTY is the looping-with-no-channels case: a pass ends on every cycle.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_HDR   = 3'd2;
  localparam logic [2:0] S_ADDR  = 3'd3;
  localparam logic [2:0] S_LVL   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_EMPTY = 3'd6;

  logic [2:0]      state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [2:0]      ch_q, ch_d;
  logic [7:0]      mask_q, mask_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0][7:0] tbl_q, tbl_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rst_q, rst_d;
  logic            data_q, data_d;
  logic            sclk_q, sclk_d;

  logic            bit_end;
  logic            in_bits;
  logic            pass_end;
  logic            go_hdr;
  logic [2:0]      hdr_ch;
  logic [3:0]      pick;
  logic [2:0]      nb;

  // Lowest enabled channel above 'ch' (or the lowest overall when 'any' is set); MSB flags a hit.
  function automatic logic [3:0] next_ch(input logic [7:0] m, input logic [2:0] ch, input logic any);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (any || (i > int'(ch)))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // Next-state: bit timing, field sequencing, channel walk, pass end and table writes.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    ch_d     = ch_q;
    mask_d   = mask_q;
    sh_d     = sh_q;
    tbl_d    = tbl_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rst_d    = rst_q;
    data_d   = data_q;
    pass_end = 1'b0;
    go_hdr   = 1'b0;
    hdr_ch   = ch_q;
    pick     = 4'd0;
    nb       = bit_q + 3'd1;

    in_bits = (state_q == S_PRE) || (state_q == S_HDR) || (state_q == S_ADDR) || (state_q == S_LVL);
    bit_end = (div_q == DIV_LAST);
    div_d   = (in_bits && !bit_end) ? div_q + 1'b1 : '0;

    if (wr_en) tbl_d[wr_addr] = wr_data;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_PRE;
          bit_d   = 3'd0;
          mask_d  = ch_mask;
          busy_d  = 1'b1;
          rst_d   = 1'b0;
          data_d  = 1'b0;
        end
      end
      S_PRE: begin
        if (bit_end) begin
          if (bit_q == 3'd3) begin
            pick = next_ch(mask_q, 3'd0, 1'b1);
            if (pick[3]) begin
              go_hdr = 1'b1;
              hdr_ch = pick[2:0];
            end else begin
              pass_end = 1'b1;
            end
          end else begin
            // Preamble pattern (0,0) (0,0) (0,1) (1,1).
            bit_d  = nb;
            rst_d  = (bit_q == 3'd2);
            data_d = (bit_q != 3'd0);
          end
        end
      end
      S_HDR: begin
        if (bit_end) begin
          state_d = S_ADDR;
          bit_d   = 3'd0;
          data_d  = ch_q[0];
        end
      end
      S_ADDR: begin
        if (bit_end) begin
          if (bit_q == 3'd2) begin
            state_d = S_LVL;
            bit_d   = 3'd0;
            data_d  = sh_q[0];
            sh_d    = {1'b0, sh_q[7:1]};
          end else begin
            bit_d  = nb;
            data_d = ch_q[nb[1:0]];
          end
        end
      end
      S_LVL: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            pick = next_ch(mask_q, ch_q, 1'b0);
            if (pick[3]) begin
              go_hdr = 1'b1;
              hdr_ch = pick[2:0];
            end else begin
              pass_end = 1'b1;
            end
          end else begin
            bit_d  = nb;
            data_d = sh_q[0];
            sh_d   = {1'b0, sh_q[7:1]};
          end
        end
      end
      S_EMPTY: pass_end = 1'b1;
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // A looped pass skips the preamble and resamples the mask.
    if (pass_end) begin
      done_d = 1'b1;
      if (loop_en) begin
        mask_d = ch_mask;
        pick   = next_ch(ch_mask, 3'd0, 1'b1);
        if (pick[3]) begin
          go_hdr = 1'b1;
          hdr_ch = pick[2:0];
        end else begin
          state_d = S_EMPTY;
        end
      end else begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        rst_d   = 1'b1;
        data_d  = 1'b1;
      end
    end

    // The level is captured here, so later table writes only affect later frames.
    if (go_hdr) begin
      state_d = S_HDR;
      ch_d    = hdr_ch;
      bit_d   = 3'd0;
      sh_d    = tbl_q[hdr_ch];
      rst_d   = 1'b1;
      data_d  = 1'b0;
    end

    sclk_d = ((state_d == S_PRE) || (state_d == S_HDR) || (state_d == S_ADDR) || (state_d == S_LVL))
             && (div_d >= DIV_HALF);
  end

  // State registers with synchronous reset; reset also clears the level table.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= 3'd0;
      ch_q    <= 3'd0;
      mask_q  <= 8'd0;
      sh_q    <= 8'd0;
      tbl_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rst_q   <= 1'b0;
      data_q  <= 1'b0;
      sclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      ch_q    <= ch_d;
      mask_q  <= mask_d;
      sh_q    <= sh_d;
      tbl_q   <= tbl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rst_q   <= rst_d;
      data_q  <= data_d;
      sclk_q  <= sclk_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign chip_rst     = rst_q;
  assign chip_clk     = sclk_q;
  assign chip_data_in = data_q;

endmodule

// File: tb/tb_dac_sweep_scheduler.sv
// Purpose: self-checking bench for dac_sweep_scheduler with a waveform-level reference model.
// Latency: model expects the first bit period the cycle after start acceptance.
// Backpressure: n/a; stimulus is driven on the falling clock edge.
module tb_dac_sweep_scheduler;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [7:0] wr_data = 8'd0;
  logic [7:0] ch_mask = 8'd0;
  logic       start = 1'b0;
  logic       loop_en = 1'b0;
  logic       busy, done, chip_rst, chip_clk, chip_data_in;
  logic [4:0] dut_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dac_sweep_scheduler #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ch_mask(ch_mask), .start(start), .loop_en(loop_en), .busy(busy), .done(done),
    .chip_rst(chip_rst), .chip_clk(chip_clk), .chip_data_in(chip_data_in)
  );

  assign dut_o = {busy, done, chip_rst, chip_clk, chip_data_in};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: generates the expected pin waveform ----------------
  logic       e_busy = 0, e_done = 0, e_rst = 0, e_clk = 0, e_data = 0;
  logic [7:0] mtbl [8];
  logic [7:0] prev_tbl [8];
  logic [7:0] m_mask = 8'd0;
  bit         abort = 0, pend_done = 0, chk_en = 0;
  logic       idle_r = 0, idle_d = 0;

  task automatic set_exp(input logic b, input logic d, input logic r, input logic c, input logic x);
    e_busy = b; e_done = d; e_rst = r; e_clk = c; e_data = x;
  endtask

  task automatic tick();
    @(posedge clk);
    prev_tbl = mtbl;
    if (rst) begin
      abort = 1;
      for (int i = 0; i < 8; i++) mtbl[i] = 8'h00;
      set_exp(0, 0, 0, 0, 0);
    end else if (wr_en) begin
      mtbl[wr_addr] = wr_data;
    end
  endtask

  task automatic send_bit(input logic r, input logic d);
    for (int c = 0; c < CLK_DIV; c++) begin
      set_exp(1, pend_done, r, (c >= CLK_DIV / 2), d);
      pend_done = 0;
      tick();
      if (abort) return;
    end
  endtask

  task automatic send_frame(input logic [2:0] ch);
    logic [7:0] lvl;
    lvl = prev_tbl[ch];
    send_bit(1, 0);
    if (abort) return;
    for (int i = 0; i < 3; i++) begin
      send_bit(1, ch[i]);
      if (abort) return;
    end
    for (int i = 0; i < 8; i++) begin
      send_bit(1, lvl[i]);
      if (abort) return;
    end
  endtask

  task automatic wait_start();
    forever begin
      tick();
      if (abort) begin
        abort = 0; idle_r = 0; idle_d = 0;
      end else if (start) begin
        m_mask = ch_mask;
        return;
      end else begin
        set_exp(0, 0, idle_r, 0, idle_d);
      end
    end
  endtask

  task automatic run_sweep();
    pend_done = 0;
    send_bit(0, 0); if (abort) return;
    send_bit(0, 0); if (abort) return;
    send_bit(0, 1); if (abort) return;
    send_bit(1, 1); if (abort) return;
    forever begin
      for (int c = 0; c < 8; c++) begin
        if (m_mask[c]) begin
          send_frame(3'(c));
          if (abort) return;
        end
      end
      if (!loop_en) begin
        set_exp(0, 1, 1, 0, 1);
        return;
      end
      m_mask = ch_mask;
      pend_done = 1;
      if (m_mask == 8'd0) begin
        set_exp(1, 1, e_rst, 0, e_data);
        pend_done = 0;
        tick();
        if (abort) return;
      end
    end
  endtask

  initial begin : model
    for (int i = 0; i < 8; i++) mtbl[i] = 8'h00;
    prev_tbl = mtbl;
    forever begin
      wait_start();
      run_sweep();
      if (abort) begin
        abort = 0; idle_r = 0; idle_d = 0;
      end else begin
        idle_r = 1; idle_d = 1;
      end
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if (dut_o !== {e_busy, e_done, e_rst, e_clk, e_data}) begin
        n_fail++;
        $display("FAIL cycle_outputs @%0t: got %b expected %b", $time, dut_o,
                 {e_busy, e_done, e_rst, e_clk, e_data});
      end
    end
  end

  // ---------------- pass monitor: bits sampled at chip_clk rise, pass timing ----------------
  logic [1:0] cap[$];
  logic [1:0] last_cap[$];
  int  cyc = 0, t_ref = 0, last_int = 0, done_cnt = 0;
  logic last_busy = 0, prev_sclk = 0, prev_busy = 0;

  always @(negedge clk) begin
    cyc++;
    if (busy && !prev_busy) begin
      t_ref = cyc;
      cap.delete();
    end
    if (chip_clk && !prev_sclk) cap.push_back({chip_rst, chip_data_in});
    if (done) begin
      last_int  = cyc - t_ref;
      t_ref     = cyc;
      last_cap  = cap;
      cap.delete();
      last_busy = busy;
      done_cnt++;
    end
    prev_sclk = chip_clk;
    prev_busy = busy;
  end

  // sel 0 packs the data bits, sel 1 the chip_rst bits, bit i = i-th sampled bit.
  function automatic logic [31:0] cap_bits(input int sel);
    logic [31:0] r;
    r = '0;
    foreach (last_cap[i]) if (i < 32) r[i] = last_cap[i][sel];
    return r;
  endfunction

  task automatic wait_done(input string name, input int budget);
    int  n0;
    bit  got;
    n0 = done_cnt;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != n0) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic write_tbl(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk) begin wr_en = 1; wr_addr = a; wr_data = d; end
    @(negedge clk) wr_en = 0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1;
    @(negedge clk) rst = 0;
    @(negedge clk);
    check("reset_outputs", 32'(dut_o), 32'h0);

    // Empty mask: preamble only.
    ch_mask = 8'h00;
    pulse_start();
    wait_done("t1_done", 100);
    check("t1_interval", last_int, 16);
    check("t1_nbits", last_cap.size(), 4);
    check("t1_data", cap_bits(0), 32'h0000000C);
    check("t1_rst", cap_bits(1), 32'h00000008);
    @(negedge clk);
    check("t1_done_state", 32'(dut_o), 32'h05);

    // Single channel 5, level 0xA5.
    write_tbl(3'd5, 8'hA5);
    ch_mask = 8'h20;
    pulse_start();
    wait_done("t2_done", 200);
    check("t2_interval", last_int, 64);
    check("t2_nbits", last_cap.size(), 16);
    check("t2_data", cap_bits(0), 32'h0000A5AC);
    check("t2_rst", cap_bits(1), 32'h0000FFF8);

    // Channels 0 and 7 back to back.
    write_tbl(3'd0, 8'h01);
    write_tbl(3'd7, 8'hFF);
    ch_mask = 8'h81;
    pulse_start();
    wait_done("t3_done", 300);
    check("t3_interval", last_int, 112);
    check("t3_nbits", last_cap.size(), 28);
    check("t3_data", cap_bits(0), 32'h0FFE010C);
    check("t3_rst", cap_bits(1), 32'h0FFFFFF8);

    // Loop mode on channel 2 with a mid-frame table write and an ignored start.
    write_tbl(3'd2, 8'h11);
    ch_mask = 8'h04;
    loop_en = 1;
    pulse_start();
    wait_done("t4_done1", 200);
    check("t4_int1", last_int, 64);
    check("t4_data1", cap_bits(0), 32'h0000114C);
    check("t4_busy1", 32'(last_busy), 32'h1);
    repeat (22) @(negedge clk);
    wr_en = 1; wr_addr = 3'd2; wr_data = 8'h3C; start = 1;
    @(negedge clk) begin wr_en = 0; start = 0; end
    wait_done("t4_done2", 100);
    check("t4_int2", last_int, 48);
    check("t4_nbits2", last_cap.size(), 12);
    check("t4_data2", cap_bits(0), 32'h00000114);
    check("t4_busy2", 32'(last_busy), 32'h1);
    wait_done("t4_done3", 100);
    check("t4_int3", last_int, 48);
    check("t4_data3", cap_bits(0), 32'h000003C4);
    @(negedge clk) loop_en = 0;
    wait_done("t4_done4", 100);
    check("t4_int4", last_int, 48);
    check("t4_busy4", 32'(last_busy), 32'h0);

    // Reset in the middle of the address field.
    pulse_start();
    check("t5_busy", 32'(busy), 32'h1);
    repeat (22) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("t5_reset_outputs", 32'(dut_o), 32'h0);
    rst = 0;
    pulse_start();
    wait_done("t5_done", 200);
    check("t5_interval", last_int, 64);
    check("t5_data", cap_bits(0), 32'h0000004C);
    check("t5_rst", cap_bits(1), 32'h0000FFF8);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
